// File: rtl/stack_sp_controller_if.sv
// Request/response and data-memory signals between the stack controller and its environment.
// slave = stack controller, master = control unit plus data memory.
interface stack_sp_controller_if;
  logic        push_req;
  logic        pop_req;
  logic [31:0] push_data;
  logic [31:0] pop_data;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic        err_underflow;
  logic [31:0] sp;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  push_req, pop_req, push_data, mem_rdata,
    output pop_data, busy, done, err_overflow, err_underflow,
           sp, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output push_req, pop_req, push_data, mem_rdata,
    input  pop_data, busy, done, err_overflow, err_underflow,
           sp, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/stack_sp_controller.sv
// Hardware stack pointer controller: owns SP and sequences push/pop accesses to data memory.
// Define STACK_BOUNDS_EN to enable full/empty checking; otherwise SP wraps modulo 2^32.
module stack_sp_controller #(
  parameter logic [31:0] STACK_BASE  = 32'h0000_0100,
  parameter int unsigned STACK_DEPTH = 64,
  parameter int unsigned MEM_LAT     = 1
) (
  input logic                  clk,
  input logic                  reset,
  stack_sp_controller_if.slave bus
);

  localparam int unsigned    CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [31:0]    STACK_TOP = STACK_BASE + 32'(STACK_DEPTH);
`ifdef STACK_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PUSH_WR, POP_RD, POP_WAIT, DONE} state_e;

  state_e           state_q;
  logic [31:0]      sp_q;
  logic [31:0]      pop_data_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             mem_we_q;
  logic             mem_re_q;
  logic             busy_q;
  logic             done_q;
  logic             err_ovf_q;
  logic             err_unf_q;
  logic             ovf_flag_q;
  logic             unf_flag_q;
  logic [CNT_W-1:0] lat_cnt_q;

  logic full;
  logic empty;

  // Bounds checks collapse to constant 0 when checking is disabled.
  assign full  = BOUNDS_EN && (sp_q == STACK_TOP);
  assign empty = BOUNDS_EN && (sp_q == STACK_BASE);

  // Memory strobes are issued on the IDLE exit edge so they are visible in the access state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sp_q        <= STACK_BASE;
      pop_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      ovf_flag_q  <= 1'b0;
      unf_flag_q  <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.push_req) begin
            state_q    <= PUSH_WR;
            busy_q     <= 1'b1;
            ovf_flag_q <= full;
            if (!full) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sp_q;
              mem_wdata_q <= bus.push_data;
            end
          end else if (bus.pop_req) begin
            state_q    <= POP_RD;
            busy_q     <= 1'b1;
            unf_flag_q <= empty;
            if (!empty) begin
              mem_re_q   <= 1'b1;
              mem_addr_q <= sp_q - 32'd1;
            end
          end
        end
        PUSH_WR: begin
          if (!ovf_flag_q) sp_q <= sp_q + 32'd1;
          done_q    <= 1'b1;
          err_ovf_q <= ovf_flag_q;
          state_q   <= DONE;
        end
        POP_RD: begin
          lat_cnt_q <= '0;
          if (unf_flag_q) begin
            done_q    <= 1'b1;
            err_unf_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            state_q <= POP_WAIT;
          end
        end
        POP_WAIT: begin
          if (lat_cnt_q == CNT_LAST) begin
            pop_data_q <= bus.mem_rdata;
            sp_q       <= sp_q - 32'd1;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pop_data      = pop_data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;
  assign bus.sp            = sp_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_re        = mem_re_q;

endmodule

// File: tb/tb_stack_sp_controller.sv
// Self-checking bench for stack_sp_controller: directed and random push/pop against a stack model.
// Honours STACK_BOUNDS_EN the same way the design does.
module tb_stack_sp_controller;

  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LAT     = 1;
  localparam int          TIMEOUT = 12;
`ifdef STACK_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  stack_sp_controller_if bus ();

  stack_sp_controller #(
    .STACK_BASE (BASE),
    .STACK_DEPTH(DEPTH),
    .MEM_LAT    (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: writes land on the strobe edge, reads return one cycle after mem_re.
  bit [31:0] tb_mem [bit [31:0]];
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= tb_mem.exists(bus.mem_addr) ? tb_mem[bus.mem_addr] : 32'd0;
  end

  // Reference model: a word array indexed by stack slot plus the pointer and last popped word.
  bit [31:0]   m_mem [bit [31:0]];
  logic [31:0] m_sp;
  logic [31:0] m_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check ("rst_sp",       bus.sp,        BASE);
    check ("rst_pop_data", bus.pop_data,  32'd0);
    check ("rst_mem_addr", bus.mem_addr,  32'd0);
    check ("rst_mem_wdata",bus.mem_wdata, 32'd0);
    check1("rst_mem_we",   bus.mem_we,    1'b0);
    check1("rst_mem_re",   bus.mem_re,    1'b0);
    check1("rst_busy",     bus.busy,      1'b0);
    check1("rst_done",     bus.done,      1'b0);
    check1("rst_err_ovf",  bus.err_overflow,  1'b0);
    check1("rst_err_unf",  bus.err_underflow, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;
    m_sp  = BASE;
    m_pop = 32'd0;
  endtask

  // One request from IDLE; optional noise requests while busy must be ignored.
  task automatic do_op(input bit psh, input bit pp, input logic [31:0] data, input bit noise);
    logic        e_we, e_re, e_ovf, e_unf, seen;
    logic [31:0] e_addr;
    int          e_cyc, cyc;
    e_we = 1'b0; e_re = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_addr = 32'd0; e_cyc = 2;
    if (psh) begin
      if (BOUNDS && m_sp == BASE + DEPTH) e_ovf = 1'b1;
      else begin
        e_we = 1'b1; e_addr = m_sp;
        m_mem[m_sp] = data;
        m_sp = m_sp + 32'd1;
      end
    end else if (pp) begin
      if (BOUNDS && m_sp == BASE) e_unf = 1'b1;
      else begin
        e_re = 1'b1; e_addr = m_sp - 32'd1; e_cyc = 2 + int'(LAT);
        m_pop = m_mem.exists(e_addr) ? m_mem[e_addr] : 32'd0;
        m_sp = e_addr;
      end
    end

    @(negedge clk);
    bus.push_req = psh; bus.pop_req = pp; bus.push_data = data;
    @(posedge clk); #1; cyc = 1;
    check1("c1_busy",   bus.busy,   1'b1);
    check1("c1_mem_we", bus.mem_we, e_we);
    check1("c1_mem_re", bus.mem_re, e_re);
    if (e_we || e_re) check("c1_mem_addr", bus.mem_addr, e_addr);
    if (e_we) check("c1_mem_wdata", bus.mem_wdata, data);
    @(negedge clk);
    bus.push_req = noise ? 1'($urandom) : 1'b0;
    bus.pop_req  = noise ? 1'($urandom) : 1'b0;
    bus.push_data = $urandom;
    @(posedge clk); #1; cyc = 2;
    seen = bus.done;
    if (!seen) check("c2_strobes", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    @(negedge clk);
    bus.push_req = 1'b0; bus.pop_req = 1'b0;
    while (!seen && cyc < TIMEOUT) begin
      @(posedge clk); #1; cyc++;
      seen = bus.done;
    end
    check ("done_cycle", 32'(cyc), 32'(e_cyc));
    check1("done_busy", bus.busy, 1'b1);
    check ("done_sp", bus.sp, m_sp);
    check ("done_pop_data", bus.pop_data, m_pop);
    check1("done_err_ovf", bus.err_overflow, e_ovf);
    check1("done_err_unf", bus.err_underflow, e_unf);
    @(posedge clk); #1;
    check1("after_done", bus.done, 1'b0);
    check1("after_busy", bus.busy, 1'b0);
  endtask

  initial begin
    logic any_done;
    int   r;
    reset = 1'b1;
    bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_data = 32'd0;
    m_sp = BASE; m_pop = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    do_op(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_op(1'b0, 1'b1, 32'd0, 1'b0);
    do_op(1'b1, 1'b0, 32'h11, 1'b0);
    do_op(1'b1, 1'b0, 32'h22, 1'b0);
    do_op(1'b0, 1'b1, 32'd0, 1'b0);
    do_op(1'b0, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 32'hA000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) do_op(1'b0, 1'b1, 32'd0, 1'b0);
    do_op(1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
    do_op(1'b0, 1'b1, 32'd0, 1'b1);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 3));
      do_op(r == 0 || r == 1 || r == 3, r == 2 || r == 3, $urandom, 1'($urandom));
    end

    // Reset while a pop waits on memory: SP must not move and no done may follow.
    apply_reset();
    do_op(1'b1, 1'b0, 32'hCAFE_0001, 1'b0);
    do_op(1'b1, 1'b0, 32'hCAFE_0002, 1'b0);
    check("pre_abort_sp", bus.sp, BASE + 32'd2);
    @(negedge clk);
    bus.pop_req = 1'b1;
    @(posedge clk); #1;
    check1("abort_c1_mem_re", bus.mem_re, 1'b1);
    @(negedge clk);
    bus.pop_req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check ("abort_sp", bus.sp, BASE);
    check1("abort_busy", bus.busy, 1'b0);
    check1("abort_mem_re", bus.mem_re, 1'b0);
    check1("abort_done", bus.done, 1'b0);
    check ("abort_mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_sp = BASE; m_pop = 32'd0;
    any_done = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      any_done = any_done | bus.done;
    end
    check1("abort_no_done", any_done, 1'b0);
    do_op(1'b1, 1'b0, 32'h1234_5678, 1'b0);
    do_op(1'b0, 1'b1, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_sp_controller.md
Name: stack_sp_controller

Overview:
Sequences push/pop operations for the processor's hardware stack: owns the stack pointer (SP), drives the data-memory port for stack accesses and applies SP increment/decrement arithmetic. Sits beside the multi-cycle control unit, which issues push/pop requests (PUSH, POP, CALL/RET return-address saves) and waits on a done pulse. Stack is word-addressed and grows upward. SP always points to the next free slot.

Parameters:
STACK_BASE, 32'h0000_0100, address of the first stack slot and SP reset value
STACK_DEPTH, 64, number of 32-bit slots
MEM_LAT, 1, data-memory read latency in cycles (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
push_req  input  1  push request, sampled only in IDLE
pop_req  input  1  pop request, sampled only in IDLE
push_data  input  32  word to push, captured with push_req
pop_data  output  32  popped word, valid when done=1 after a pop
busy  output  1  high whenever FSM is not in IDLE
done  output  1  one-cycle completion pulse
err_overflow  output  1  one-cycle pulse with done: push refused, stack full
err_underflow  output  1  one-cycle pulse with done: pop refused, stack empty
sp  output  32  current stack pointer
mem_addr  output  32  data-memory address
mem_wdata  output  32  data-memory write data
mem_we  output  1  data-memory write enable
mem_re  output  1  data-memory read enable
mem_rdata  input  32  data-memory read data, valid MEM_LAT cycles after mem_re

Behaviour:
- Reset (async, any state): FSM=IDLE, sp=STACK_BASE, pop_data=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, done=0, err_*=0. In-flight operation is abandoned; no partial SP update.
- States: IDLE, PUSH_WR, POP_RD, POP_WAIT, DONE.
- IDLE: push_req=1 -> capture push_data, go PUSH_WR. Else pop_req=1 -> go POP_RD. Push_req and pop_req both high: push wins, pop dropped; requester must re-issue it.
- Requests while busy=1 are ignored, not queued.
- PUSH_WR (1 cycle): if full (sp == STACK_BASE+STACK_DEPTH), no write, set overflow flag. Else mem_addr=sp, mem_wdata=captured data, mem_we=1; sp<=sp+1. Next: DONE.
- POP_RD (1 cycle): if empty (sp == STACK_BASE), no read, set underflow flag, go DONE. Else mem_addr=sp-1, mem_re=1, go POP_WAIT.
- POP_WAIT: counts MEM_LAT cycles, holding mem_addr. On the final count, pop_data<=mem_rdata and sp<=sp-1. Next: DONE.
- DONE (1 cycle): done=1, err_overflow/err_underflow=stored flag, then IDLE. pop_data holds until the next successful pop.
- Latency (request sampled cycle 0): push -> mem_we at cycle 1, done at cycle 2. Pop -> mem_re at cycle 1, done at cycle 2+MEM_LAT.
- mem_we/mem_re are single-cycle pulses, never both high together. SP arithmetic is 32-bit unsigned.
- sp is registered; the updated value is visible in the cycle done is high.

Optional Feature:
STACK_BOUNDS_EN: when defined, full/empty checks and err_overflow/err_underflow apply as above. When undefined, no checks: every push writes and increments, every pop reads and decrements, SP wraps modulo 2^32 (0xFFFF_FFFF+1 -> 0, 0-1 -> 0xFFFF_FFFF), and err_* are tied 0.

Test Plan:
(STACK_BASE=0x100, STACK_DEPTH=4, MEM_LAT=1, STACK_BOUNDS_EN defined unless noted)
- Push 0xDEADBEEF from reset -> cycle 1: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cycle 2: done=1, sp=0x101.
- Push 0x11, 0x22, then pop twice -> pops return 0x22 then 0x11; mem_addr=0x101 then 0x100; done at cycle 3 of each pop; final sp=0x100.
- Five pushes -> first four succeed (sp=0x104); fifth: no mem_we, done with err_overflow=1, sp stays 0x104.
- Pop at sp=0x100 -> no mem_re, done with err_underflow=1, pop_data unchanged. Without STACK_BOUNDS_EN: mem_addr=0xFF, sp=0xFF after done.
- push_req and pop_req high together in IDLE -> push performed, pop ignored. Requests raised while busy=1 -> no effect.
- Assert reset during POP_WAIT with sp=0x102 -> immediately sp=0x100, busy=0, mem_re=0; no done pulse follows.
